// File: rtl/tetris_pkg.sv
// Shared types and default dimensions for the tetris game controller.
package tetris_pkg;

    localparam int ROWS_DEF   = 22;
    localparam int COLS_DEF   = 10;
    localparam int LINE_W_DEF = 16;

    typedef enum logic [2:0] {
        SPAWN,
        FALLING,
        MERGE,
        CLEAR,
        GAMEOVER
    } game_state_t;

endpackage

// File: rtl/tetris_game_ctrl_if.sv
// Spawn handshake between the game controller (master) and the block generator (slave).
interface tetris_game_ctrl_if #(
    parameter int ROWS = tetris_pkg::ROWS_DEF,
    parameter int COLS = tetris_pkg::COLS_DEF
);
    logic                       spawn_req;
    logic                       spawn_valid;
    logic [ROWS-1:0][COLS-1:0]  spawn_piece;

    modport master (output spawn_req, input spawn_valid, input spawn_piece);
    modport slave  (input spawn_req, output spawn_valid, output spawn_piece);
endinterface

// File: rtl/tetris_row_collapse.sv
// Removes row row_i from the grid, dropping every row above it by one; row 0 refills with zeros.
module tetris_row_collapse #(
    parameter int ROWS = tetris_pkg::ROWS_DEF,
    parameter int COLS = tetris_pkg::COLS_DEF,
    parameter int RW   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic [ROWS-1:0][COLS-1:0] grid_i,
    input  logic [RW-1:0]             row_i,
    output logic [ROWS-1:0][COLS-1:0] grid_o,
    output logic                      row_full_o
);

    always_comb begin
        grid_o    = grid_i;
        grid_o[0] = '0;
        for (int i = 1; i < ROWS; i++) begin
            if (RW'(i) <= row_i) grid_o[i] = grid_i[i-1];
        end
        row_full_o = &grid_i[row_i];
    end

endmodule

// File: rtl/tetris_game_ctrl.sv
// Game controller: owns the stored grid and the falling piece, handles spawn, gravity,
// lateral moves, merging, bottom-up row clearing and game-over detection.
module tetris_game_ctrl
    import tetris_pkg::*;
#(
    parameter int ROWS   = ROWS_DEF,
    parameter int COLS   = COLS_DEF,
    parameter int LINE_W = LINE_W_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      tick_i,
    input  logic                      move_left_i,
    input  logic                      move_right_i,
    tetris_game_ctrl_if.master        spawn_if,
    output logic [ROWS-1:0][COLS-1:0] display_array_o,
    output logic                      landed_o,
    output logic                      line_clr_o,
    output logic [LINE_W-1:0]         lines_total_o,
    output logic                      game_over_o
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    typedef logic [ROWS-1:0][COLS-1:0] grid_t;

    // Row r moves to row r+1 (towards the bottom).
    function automatic grid_t shift_down(input grid_t g);
        grid_t r;
        r = '0;
        for (int i = 1; i < ROWS; i++) r[i] = g[i-1];
        return r;
    endfunction

    // Bit 0 is the leftmost column, so "left" is a right shift within each row.
    function automatic grid_t shift_lr(input grid_t g, input logic to_left);
        grid_t r;
        for (int i = 0; i < ROWS; i++) r[i] = to_left ? (g[i] >> 1) : (g[i] << 1);
        return r;
    endfunction

    function automatic logic col_hit(input grid_t g, input int col);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < ROWS; i++) hit = hit | g[i][col];
        return hit;
    endfunction

    game_state_t       state_q, state_d;
    grid_t             stored_q, stored_d;
    grid_t             falling_q, falling_d;
    logic [RW-1:0]     scan_q, scan_d;
    logic [LINE_W-1:0] lines_q, lines_d;

    grid_t collapsed;
    logic  row_full;
    logic  down_blk, left_blk, right_blk, spawn_req;

    tetris_row_collapse #(.ROWS(ROWS), .COLS(COLS), .RW(RW)) u_collapse (
        .grid_i     (stored_q),
        .row_i      (scan_q),
        .grid_o     (collapsed),
        .row_full_o (row_full)
    );

    always_comb begin
        down_blk  = (|falling_q[ROWS-1]) | (|(shift_down(falling_q) & stored_q));
        left_blk  = col_hit(falling_q, 0) | (|(shift_lr(falling_q, 1'b1) & stored_q));
        right_blk = col_hit(falling_q, COLS-1) | (|(shift_lr(falling_q, 1'b0) & stored_q));
    end

    always_comb begin
        state_d         = state_q;
        stored_d        = stored_q;
        falling_d       = falling_q;
        scan_d          = scan_q;
        lines_d         = lines_q;
        spawn_req       = 1'b0;
        landed_o        = 1'b0;
        line_clr_o      = 1'b0;
        game_over_o     = 1'b0;
        display_array_o = stored_q;

        case (state_q)
            SPAWN: begin
                spawn_req = 1'b1;
                if (spawn_if.spawn_valid) begin
                    if (|(spawn_if.spawn_piece & stored_q)) begin
                        state_d = GAMEOVER;
                    end else begin
                        falling_d = spawn_if.spawn_piece;
                        state_d   = FALLING;
                    end
                end
            end
            FALLING: begin
                display_array_o = stored_q | falling_q;
                if (tick_i) begin
                    if (down_blk) state_d = MERGE;
                    else          falling_d = shift_down(falling_q);
                end else if (move_left_i && !move_right_i) begin
                    if (!left_blk) falling_d = shift_lr(falling_q, 1'b1);
                end else if (move_right_i && !move_left_i) begin
                    if (!right_blk) falling_d = shift_lr(falling_q, 1'b0);
                end
            end
            MERGE: begin
                display_array_o = stored_q | falling_q;
                landed_o        = 1'b1;
                stored_d        = stored_q | falling_q;
                falling_d       = '0;
                scan_d          = RW'(ROWS-1);
                state_d         = CLEAR;
            end
            CLEAR: begin
                // A cleared row is re-tested next cycle since the row above has dropped into it.
                if (row_full) begin
                    stored_d   = collapsed;
                    line_clr_o = 1'b1;
                    if (lines_q != '1) lines_d = lines_q + 1'b1;
                end else if (scan_q == '0) begin
                    state_d = SPAWN;
                end else begin
                    scan_d = scan_q - 1'b1;
                end
            end
            GAMEOVER: begin
                game_over_o = 1'b1;
            end
            default: state_d = SPAWN;
        endcase
    end

    assign spawn_if.spawn_req = spawn_req;
    assign lines_total_o      = lines_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= SPAWN;
            stored_q  <= '0;
            falling_q <= '0;
            scan_q    <= RW'(ROWS-1);
            lines_q   <= '0;
        end else begin
            state_q   <= state_d;
            stored_q  <= stored_d;
            falling_q <= falling_d;
            scan_q    <= scan_d;
            lines_q   <= lines_d;
        end
    end

endmodule
